// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 2 KB video/character BRAM between the Z80 CPU and video scan-out.
// Latency: RAM port is combinational from the grant; cpu_ack, vid_valid and vid_miss arrive 1 cycle after the grant.
// Backpressure: the CPU is stalled through cpu_wait_n. Video is never stalled, and a denied fetch is reported by vid_miss.
//
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack      registered read data (held), one-cycle completion pulse
//   cpu_wait_n              low while the CPU request is pending and not granted
//   vid_req/addr            video fetch request, one cycle per byte
//   vid_rdata/valid/miss    fetch data, data-valid flag, dropped-fetch flag
//   ram_addr/we/wdata/rdata synchronous BRAM port (1-cycle read latency)
//   stall_cnt               CPU contention counter. It is built only with `define VRAM_ARB_STATS_EN and reads 0 otherwise.
module vram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic              vid_miss,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] MAX_S = 4'(MAX_STARVE);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              inflight_q;
  logic              cpu_ack_q;
  logic              rd_done_q;   // the access being acked is a read
  logic              vid_valid_q;
  logic              vid_miss_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic cpu_pend;
  logic grant_cpu;
  logic grant_vid;
  logic cpu_denied;

  // inflight masks the ack cycle, so a request that is still held is not granted a second time.
  assign cpu_pend   = cpu_req & ~inflight_q;
  assign grant_cpu  = cpu_pend & (~vid_req | (starve_cnt_q == MAX_S));
  assign grant_vid  = vid_req & ~grant_cpu;
  assign cpu_denied = cpu_pend & ~grant_cpu;

  // RAM port mux. A write that is granted while reset is asserted is suppressed.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we & reset_n;
    end
  end

  assign cpu_wait_n = ~reset_n | ~cpu_denied;

  always_comb begin
    starve_cnt_d = 4'd0;
    if (cpu_denied) begin
      starve_cnt_d = (starve_cnt_q == MAX_S) ? MAX_S : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= 4'd0;
      inflight_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_miss_q   <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      inflight_q   <= grant_cpu;
      cpu_ack_q    <= grant_cpu;
      rd_done_q    <= grant_cpu & ~cpu_we;
      vid_valid_q  <= grant_vid;
      vid_miss_q   <= vid_req & grant_cpu;
      // The BRAM presents read data during the ack cycle. It is captured here and held until the next read.
      if (cpu_ack_q && rd_done_q) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_miss  = vid_miss_q;
  assign vid_rdata = ram_rdata;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!cpu_wait_n && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_wait_n;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_valid, vid_miss;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [15:0] stall_cnt;

  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_dat;
  logic [7:0]  mem [0:2047];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_cnt(stall_cnt)
  );

  // Synchronous single-port BRAM with 1-cycle read latency (read-before-write).
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_dat;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Inputs change 1 time unit after posedge. Outputs are sampled 2 time units later, well away from either edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
  endtask

  task automatic test_reset;
    reset_n = 0; idle_inputs(); pre_we = 0; pre_addr = '0; pre_dat = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      pre_we = 1; pre_addr = 11'(i); pre_dat = pat(11'(i));
      tick();
    end
    pre_we = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h7FF; cpu_wdata = 8'hEE;
    #2;
    vectors++;
    if (cpu_ack !== 1'b0 || vid_valid !== 1'b0 || vid_miss !== 1'b0 || cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_regs: ack=%b valid=%b miss=%b rdata=%h, expected 0 0 0 00",
               cpu_ack, vid_valid, vid_miss, cpu_rdata);
    end
    vectors++;
    if (ram_we !== 1'b0 || cpu_wait_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_forced: ram_we=%b wait_n=%b, expected 0 1", ram_we, cpu_wait_n);
    end
    tick();
    idle_inputs();
    reset_n = 1;
    tick();
  endtask

  task automatic test_cpu_write;
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h123; cpu_wdata = 8'hA5;
    #2;
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== 11'h123 || ram_wdata !== 8'hA5 || cpu_wait_n !== 1'b1 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_grant: we=%b addr=%h wdata=%h wait_n=%b ack=%b, expected 1 123 a5 1 0",
               ram_we, ram_addr, ram_wdata, cpu_wait_n, cpu_ack);
    end
    tick();
    #2;
    vectors++;
    if (cpu_ack !== 1'b1 || ram_we !== 1'b0 || cpu_wait_n !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ack: ack=%b we=%b wait_n=%b, expected 1 0 1", cpu_ack, ram_we, cpu_wait_n);
    end
    tick();
    idle_inputs();
    #2;
    vectors++;
    if (cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ack_end: ack=%b, expected 0", cpu_ack);
    end
    tick();
  endtask

  task automatic test_cpu_read;
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'h123;
    #2;
    vectors++;
    if (ram_we !== 1'b0 || ram_addr !== 11'h123 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_grant: we=%b addr=%h ack=%b, expected 0 123 0", ram_we, ram_addr, cpu_ack);
    end
    tick();
    #2;
    vectors++;
    if (cpu_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_ack: ack=%b, expected 1", cpu_ack);
    end
    tick();
    cpu_req = 0;
    #2;
    vectors++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_data: ack=%b rdata=%h, expected 0 a5", cpu_ack, cpu_rdata);
    end
    tick();
    tick();
    #2;
    vectors++;
    if (cpu_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_hold: rdata=%h, expected a5", cpu_rdata);
    end
    tick();
  endtask

  task automatic test_video_stream;
    for (int k = 0; k <= 9; k++) begin
      vid_req = (k < 8); vid_addr = (k < 8) ? 11'(k) : 11'h0;
      #2;
      vectors++;
      if (vid_valid !== (k >= 1 && k <= 8) || vid_miss !== 1'b0 ||
          ((k >= 1 && k <= 8) && vid_rdata !== pat(11'(k - 1)))) begin
        miscompares++;
        $display("FAIL vid_stream[%0d]: valid=%b miss=%b rdata=%h, expected %b 0 %h",
                 k, vid_valid, vid_miss, vid_rdata, (k >= 1 && k <= 8), pat(11'(k - 1)));
      end
      tick();
    end
  endtask

  // A CPU read of address 2 against continuous video fetches. The CPU is denied 4 cycles and granted on the 5th.
  task automatic test_starvation;
    logic [6:0] e_wait, e_ack, e_miss, e_valid;
    e_wait  = 7'b1110000;  // bit index = cycle
    e_ack   = 7'b0100000;
    e_miss  = 7'b0100000;
    e_valid = 7'b1011110;
    for (int c = 0; c < 7; c++) begin
      vid_req  = (c < 6);
      vid_addr = 11'h0;
      cpu_req  = (c < 6); cpu_we = 0; cpu_addr = 11'h002;
      #2;
      vectors++;
      if (cpu_wait_n !== e_wait[c] || cpu_ack !== e_ack[c] || vid_miss !== e_miss[c] || vid_valid !== e_valid[c]) begin
        miscompares++;
        $display("FAIL starve[%0d]: wait_n=%b ack=%b miss=%b valid=%b, expected %b %b %b %b",
                 c, cpu_wait_n, cpu_ack, vid_miss, vid_valid, e_wait[c], e_ack[c], e_miss[c], e_valid[c]);
      end
      if (c == 4) begin
        vectors++;
        if (ram_addr !== 11'h002) begin
          miscompares++;
          $display("FAIL starve_addr: ram_addr=%h, expected 002", ram_addr);
        end
      end
      tick();
    end
    idle_inputs();
    #2;
    vectors++;
    if (cpu_rdata !== pat(11'h002)) begin
      miscompares++;
      $display("FAIL starve_rdata: rdata=%h, expected %h", cpu_rdata, pat(11'h002));
    end
    tick();
  endtask

  task automatic test_reset_mid;
    // A write that is granted during reset must not reach the RAM, and the held request is granted after release.
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h200; cpu_wdata = 8'h3C;
    reset_n = 0;
    #2;
    vectors++;
    if (ram_we !== 1'b0 || cpu_wait_n !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wr_supp: ram_we=%b wait_n=%b, expected 0 1", ram_we, cpu_wait_n);
    end
    tick();
    reset_n = 1;
    #2;
    vectors++;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 11'h200) begin
      miscompares++;
      $display("FAIL rst_regrant: ack=%b ram_we=%b addr=%h, expected 0 1 200", cpu_ack, ram_we, ram_addr);
    end
    tick();
    #2;
    vectors++;
    if (cpu_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ack: ack=%b, expected 1", cpu_ack);
    end
    tick();
    idle_inputs();
    tick();
    // Build up starvation, then reset. The counter must restart at zero, and the pending vid_valid is dropped.
    vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001;
    tick(); tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    #2;
    vectors++;
    if (vid_valid !== 1'b0 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_cancel: valid=%b ack=%b, expected 0 0", vid_valid, cpu_ack);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) #2;
      vectors++;
      if (cpu_wait_n !== (c == 4)) begin
        miscompares++;
        $display("FAIL rst_starve[%0d]: wait_n=%b, expected %b", c, cpu_wait_n, (c == 4));
      end
      tick();
    end
    cpu_req = 0; vid_req = 0;
    tick();
    tick();
  endtask

  task automatic test_stats;
    logic [15:0] exp_cnt;
    reset_n = 0; idle_inputs();
    tick();
    reset_n = 1;
    tick();
    for (int r = 0; r < 3; r++) test_starvation();
`ifdef VRAM_ARB_STATS_EN
    exp_cnt = 16'd12;
`else
    exp_cnt = 16'd0;
`endif
    #2;
    vectors++;
    if (stall_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_video_stream();
    test_starvation();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
